dmem_responder: RTL

- Data-memory target for the pipeline's MEM-stage dmem port. It is the responder end of the initiator that drives dmem_addr, dmem_rmask, dmem_wmask and dmem_wdata.
- Holds a word-addressed, byte-writable storage array. It services one read or write at a time and returns dmem_rdata with a one-cycle dmem_resp pulse after a programmable latency.
- Used as the pipeline's data memory in simulation and in FPGA bring-up.

---
 rtl/dmem_if.sv | 31 +++
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM-stage initiator and the data memory.
// The initiator drives address, masks and write data; the responder returns data and handshake.
interface dmem_if;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        dmem_ready;

   modport master (
      output dmem_addr,
      output dmem_rmask,
      output dmem_wmask,
      output dmem_wdata,
      input  dmem_rdata,
      input  dmem_resp,
      input  dmem_ready
   );

   modport slave (
      input  dmem_addr,
      input  dmem_rmask,
      input  dmem_wmask,
      input  dmem_wdata,
      output dmem_rdata,
      output dmem_resp,
      output dmem_ready
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed, byte-writable data memory that answers one request at a time
// with a single-cycle dmem_resp pulse a fixed LATENCY cycles after acceptance.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus,
   output logic   err
);

   localparam int         AW     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t state_next;

   logic [3:0]    counter;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          req;
   logic          ready;
   logic          resp;
   logic          accept;
   logic          commit;

   logic [31:2]   offset_w;
   logic          in_range_now;
   logic [AW-1:0] idx_now;

   logic [AW-1:0] cap_idx;
   logic [3:0]    cap_rmask;
   logic [3:0]    cap_wmask;
   logic [31:0]   cap_wdata;
   logic          cap_write;
   logic          cap_in_range;

   logic [AW-1:0] op_idx;
   logic [3:0]    op_rmask;
   logic [3:0]    op_wmask;
   logic [31:0]   op_wdata;
   logic          op_write;
   logic          op_in_range;

   logic [31:0]   rdata_q;

   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = {8{m[i]}};
      end
      return r;
   endfunction

   // Word offset uses unsigned wrap-around; addresses below the base fail the compare.
   assign req          = (bus.dmem_rmask | bus.dmem_wmask) != 4'b0000;
   assign offset_w     = bus.dmem_addr[31:2] - BASE_ADDR[31:2];
   assign in_range_now = (bus.dmem_addr >= BASE_ADDR) && (offset_w[31:AW+2] == '0);
   assign idx_now      = offset_w[AW+1:2];
   assign accept       = ready && req;
   assign commit       = ((state == WAIT) && (counter == 4'd1)) || (accept && (LATENCY == 1));

   // With single-cycle latency the commit edge is the accept edge, so the live request is used.
   generate
      if (LATENCY == 1) begin : g_op_live
         assign op_idx      = idx_now;
         assign op_rmask    = bus.dmem_rmask;
         assign op_wmask    = bus.dmem_wmask;
         assign op_wdata    = bus.dmem_wdata;
         assign op_write    = bus.dmem_wmask != 4'b0000;
         assign op_in_range = in_range_now;
      end else begin : g_op_captured
         assign op_idx      = cap_idx;
         assign op_rmask    = cap_rmask;
         assign op_wmask    = cap_wmask;
         assign op_wdata    = cap_wdata;
         assign op_write    = cap_write;
         assign op_in_range = cap_in_range;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               state_next = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (counter == 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (req) begin
               state_next = (LATENCY == 1) ? RESP : WAIT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b1;
      resp  = 1'b0;
      case (state)
         IDLE: ready = 1'b1;
         WAIT: ready = 1'b0;
         RESP: begin
            ready = 1'b1;
            resp  = 1'b1;
         end
         default: ready = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter      <= '0;
         cap_idx      <= '0;
         cap_rmask    <= '0;
         cap_wmask    <= '0;
         cap_wdata    <= '0;
         cap_write    <= 1'b0;
         cap_in_range <= 1'b0;
         rdata_q      <= '0;
         err          <= 1'b0;
      end else begin
         if (accept) begin
            counter      <= LAT_M1;
            cap_idx      <= idx_now;
            cap_rmask    <= bus.dmem_rmask;
            cap_wmask    <= bus.dmem_wmask;
            cap_wdata    <= bus.dmem_wdata;
            cap_write    <= bus.dmem_wmask != 4'b0000;
            cap_in_range <= in_range_now;
         end else if (state == WAIT) begin
            counter <= counter - 4'd1;
         end

         if (commit && !op_write) begin
            rdata_q <= op_in_range ? (mem[op_idx] & lane_mask(op_rmask)) : 32'h0000_0000;
         end

         // Sticky: ignored request, ambiguous read+write, or address outside the array.
         if ((req && !ready) ||
             (accept && (bus.dmem_rmask != 4'b0000) && (bus.dmem_wmask != 4'b0000)) ||
             (accept && !in_range_now)) begin
            err <= 1'b1;
         end
      end
   end

   // Array is not reset; the rst gate keeps an aborted or reset-time request from committing.
   always_ff @(posedge clk) begin
      if (commit && op_write && op_in_range && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (op_wmask[i]) begin
               mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.dmem_rdata = rdata_q;
   assign bus.dmem_resp  = resp;
   assign bus.dmem_ready = ready;

endmodule
